// File: rtl/xcorr_peak_finder_pkg.sv
// Shared definitions for the cross-correlation peak finder.
// Holds the FSM state encoding, a ceiling-log2 helper that never returns
// less than 1, and the accumulator width computation.
package xcorr_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_MAC   = 3'd2,
      ST_CMP   = 3'd3,
      ST_DONE  = 3'd4
   } xcorr_state_e;

   // Ceiling log2, minimum 1 so that single-entry fields still get one bit.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

   // Product width plus enough headroom to sum TEMPL_LEN products.
   function automatic int acc_w(input int data_w, input int templ_len);
      return 2 * data_w + clog2(templ_len);
   endfunction

endpackage

// File: rtl/xcorr_peak_finder_if.sv
// Bus interface of xcorr_peak_finder: run control, template/sample write
// ports, packed per-channel results and the FSM state for observation.
//   master : drives ena, start, templ_*, samp_*
//   slave  : drives busy, rdy, peak_val, peak_lag, dbg_state
//
// Run handshake: start is sampled on an enabled clock edge while busy=0 and
// launches a run; busy is high from the next cycle until the results are
// ready; rdy is a single enabled-cycle pulse, and peak_val/peak_lag are valid
// from that pulse until the next run's lag-0 compare. start and writes are
// ignored while busy=1.
interface xcorr_peak_finder_if #(
   parameter int DATA_W    = 16,
   parameter int TEMPL_LEN = 32,
   parameter int MAX_LAG   = 64,
   parameter int CH        = 2
);
   localparam int ACC_W = xcorr_pkg::acc_w(DATA_W, TEMPL_LEN);
   localparam int LAG_W = xcorr_pkg::clog2(MAX_LAG + 1);
   localparam int TA_W  = xcorr_pkg::clog2(TEMPL_LEN);
   localparam int SA_W  = xcorr_pkg::clog2(TEMPL_LEN + MAX_LAG);
   localparam int CH_W  = xcorr_pkg::clog2(CH);

   logic                  ena;
   logic                  start;
   logic                  busy;
   logic                  rdy;
   logic                  templ_we;
   logic [TA_W-1:0]       templ_addr;
   logic [DATA_W-1:0]     templ_data;
   logic                  samp_we;
   logic [CH_W-1:0]       samp_ch;
   logic [SA_W-1:0]       samp_addr;
   logic [DATA_W-1:0]     samp_data;
   logic [CH*ACC_W-1:0]   peak_val;
   logic [CH*LAG_W-1:0]   peak_lag;
   xcorr_pkg::xcorr_state_e dbg_state;

   modport master (
      output ena, start, templ_we, templ_addr, templ_data,
             samp_we, samp_ch, samp_addr, samp_data,
      input  busy, rdy, peak_val, peak_lag, dbg_state
   );

   modport slave (
      input  ena, start, templ_we, templ_addr, templ_data,
             samp_we, samp_ch, samp_addr, samp_data,
      output busy, rdy, peak_val, peak_lag, dbg_state
   );

endinterface

// File: rtl/xcorr_peak_finder_mac_lane.sv
// One channel of the correlator: signed multiply-accumulate, and the
// peak register pair updated in the compare step.
//   clk, rst          : clock, async active-high reset
//   ena_i             : clock enable
//   acc_clr_i         : zero the accumulator (run start)
//   mac_en_i          : add templ_i*samp_i into the accumulator
//   cmp_en_i          : compare/update peak, then zero the accumulator
//   first_lag_i       : lag 0 -- load the peak unconditionally
//   lag_i             : lag currently being compared
//   templ_i, samp_i   : signed operands
//   peak_val_o/lag_o  : signed peak correlation and its lag
module xcorr_mac_lane #(
   parameter int DATA_W   = 16,
   parameter int ACC_W    = 34,
   parameter int LAG_W    = 3,
   parameter int MODE_ABS = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ena_i,
   input  logic                     acc_clr_i,
   input  logic                     mac_en_i,
   input  logic                     cmp_en_i,
   input  logic                     first_lag_i,
   input  logic [LAG_W-1:0]         lag_i,
   input  logic signed [DATA_W-1:0] templ_i,
   input  logic signed [DATA_W-1:0] samp_i,
   output logic signed [ACC_W-1:0]  peak_val_o,
   output logic [LAG_W-1:0]         peak_lag_o
);

   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]    prod_ext;
   logic signed [ACC_W-1:0]    acc_q, acc_d;
   logic signed [ACC_W-1:0]    peak_val_q, peak_val_d;
   logic [LAG_W-1:0]           peak_lag_q, peak_lag_d;

   // One extra bit so |most negative| stays representable and the signed
   // compare works in both modes.
   function automatic logic signed [ACC_W:0] metric(input logic signed [ACC_W-1:0] v);
      logic signed [ACC_W:0] e;
      e = {v[ACC_W-1], v};
      if (MODE_ABS != 0 && e < 0) e = -e;
      return e;
   endfunction

   assign prod     = templ_i * samp_i;
   assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

   always_comb begin
      acc_d      = acc_q;
      peak_val_d = peak_val_q;
      peak_lag_d = peak_lag_q;
      if (acc_clr_i) begin
         acc_d = '0;
      end else if (mac_en_i) begin
         acc_d = acc_q + prod_ext;
      end
      if (cmp_en_i) begin
         acc_d = '0;
         // Strict > keeps the earliest lag on ties.
         if (first_lag_i || (metric(acc_q) > metric(peak_val_q))) begin
            peak_val_d = acc_q;
            peak_lag_d = lag_i;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q      <= '0;
         peak_val_q <= '0;
         peak_lag_q <= '0;
      end else if (ena_i) begin
         acc_q      <= acc_d;
         peak_val_q <= peak_val_d;
         peak_lag_q <= peak_lag_d;
      end
   end

   assign peak_val_o = peak_val_q;
   assign peak_lag_o = peak_lag_q;

endmodule

// File: rtl/xcorr_peak_finder.sv
// Multi-channel cross-correlation peak finder. A template and CH sample
// records are written into register stores while idle; a run then
// correlates the template against every channel for lags 0..MAX_LAG, one
// tap per cycle, and reports each channel's peak correlation and lag.
//   clk, rst : clock, async active-high reset
//   bus      : xcorr_peak_finder_if slave (control, writes, results)
module xcorr_peak_finder
   import xcorr_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int TEMPL_LEN = 32,
   parameter int MAX_LAG   = 64,
   parameter int CH        = 2,
   parameter int MODE_ABS  = 0
) (
   input  logic               clk,
   input  logic               rst,
   xcorr_peak_finder_if.slave bus
);

   localparam int ACC_W  = acc_w(DATA_W, TEMPL_LEN);
   localparam int LAG_W  = clog2(MAX_LAG + 1);
   localparam int TA_W   = clog2(TEMPL_LEN);
   localparam int SA_W   = clog2(TEMPL_LEN + MAX_LAG);
   localparam int SAMP_N = TEMPL_LEN + MAX_LAG;
   localparam logic [TA_W-1:0]  J_LAST   = TA_W'(TEMPL_LEN - 1);
   localparam logic [LAG_W-1:0] LAG_LAST = LAG_W'(MAX_LAG);

   xcorr_state_e      state_q, state_d;
   logic [LAG_W-1:0]  lag_q, lag_d;
   logic [TA_W-1:0]   j_q, j_d;
   logic              rdy_q, rdy_d;
   logic              busy;
   logic [SA_W-1:0]   samp_idx;

   logic signed [DATA_W-1:0] templ_q [TEMPL_LEN];
   logic signed [DATA_W-1:0] samp_q  [CH][SAMP_N];
   logic [ACC_W-1:0]         lane_val [CH];
   logic [LAG_W-1:0]         lane_lag [CH];

   assign busy = (state_q != ST_IDLE);

   // Data stores are deliberately outside the reset domain so a reset
   // mid-run keeps the loaded template and samples.
   always_ff @(posedge clk) begin
      if (bus.ena && !busy) begin
         if (bus.templ_we && int'(bus.templ_addr) < TEMPL_LEN)
            templ_q[bus.templ_addr] <= bus.templ_data;
         if (bus.samp_we && int'(bus.samp_ch) < CH && int'(bus.samp_addr) < SAMP_N)
            samp_q[bus.samp_ch][bus.samp_addr] <= bus.samp_data;
      end
   end

   always_comb begin
      state_d = state_q;
      lag_d   = lag_q;
      j_d     = j_q;
      rdy_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) state_d = ST_CLEAR;
         end
         ST_CLEAR: begin
            lag_d   = '0;
            j_d     = '0;
            state_d = ST_MAC;
         end
         ST_MAC: begin
            if (j_q == J_LAST) state_d = ST_CMP;
            else               j_d     = j_q + 1'b1;
         end
         ST_CMP: begin
            j_d = '0;
            if (lag_q == LAG_LAST) begin
               state_d = ST_DONE;
            end else begin
               lag_d   = lag_q + 1'b1;
               state_d = ST_MAC;
            end
         end
         ST_DONE: begin
            // rdy is registered so it rises together with the return to idle.
            rdy_d   = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         lag_q   <= '0;
         j_q     <= '0;
         rdy_q   <= 1'b0;
      end else if (bus.ena) begin
         state_q <= state_d;
         lag_q   <= lag_d;
         j_q     <= j_d;
         rdy_q   <= rdy_d;
      end
   end

   assign samp_idx = SA_W'(lag_q) + SA_W'(j_q);

   for (genvar c = 0; c < CH; c++) begin : g_lane
      xcorr_mac_lane #(
         .DATA_W   (DATA_W),
         .ACC_W    (ACC_W),
         .LAG_W    (LAG_W),
         .MODE_ABS (MODE_ABS)
      ) u_lane (
         .clk         (clk),
         .rst         (rst),
         .ena_i       (bus.ena),
         .acc_clr_i   (state_q == ST_CLEAR),
         .mac_en_i    (state_q == ST_MAC),
         .cmp_en_i    (state_q == ST_CMP),
         .first_lag_i (lag_q == '0),
         .lag_i       (lag_q),
         .templ_i     (templ_q[j_q]),
         .samp_i      (samp_q[c][samp_idx]),
         .peak_val_o  (lane_val[c]),
         .peak_lag_o  (lane_lag[c])
      );
   end

   always_comb begin
      bus.peak_val = '0;
      bus.peak_lag = '0;
      for (int c = 0; c < CH; c++) begin
         bus.peak_val[c*ACC_W +: ACC_W] = lane_val[c];
         bus.peak_lag[c*LAG_W +: LAG_W] = lane_lag[c];
      end
   end

   // rdy_q would otherwise linger across disabled cycles; gating keeps the
   // pulse to exactly one enabled cycle.
   assign bus.rdy       = rdy_q & bus.ena;
   assign bus.busy      = busy;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_xcorr_peak_finder.sv
// Bench for xcorr_peak_finder: two instances (MODE_ABS=0 and 1) share one
// stimulus stream. Directed table entries, hand-written multi-cycle corner
// sequences and randomized runs checked against a lag-by-lag arithmetic model.
module tb_xcorr_peak_finder;
   import xcorr_pkg::*;

   localparam int DATA_W = 16;
   localparam int TL     = 4;
   localparam int ML     = 7;
   localparam int CH     = 2;
   localparam int SN     = TL + ML;
   localparam int ACC_W  = acc_w(DATA_W, TL);
   localparam int LAG_W  = clog2(ML + 1);
   localparam int TA_W   = clog2(TL);
   localparam int SA_W   = clog2(SN);
   localparam int LAT    = 2 + (ML + 1) * (TL + 1);

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   xcorr_peak_finder_if #(.DATA_W(DATA_W), .TEMPL_LEN(TL), .MAX_LAG(ML), .CH(CH)) bus0 ();
   xcorr_peak_finder_if #(.DATA_W(DATA_W), .TEMPL_LEN(TL), .MAX_LAG(ML), .CH(CH)) bus1 ();

   assign bus1.ena        = bus0.ena;
   assign bus1.start      = bus0.start;
   assign bus1.templ_we   = bus0.templ_we;
   assign bus1.templ_addr = bus0.templ_addr;
   assign bus1.templ_data = bus0.templ_data;
   assign bus1.samp_we    = bus0.samp_we;
   assign bus1.samp_ch    = bus0.samp_ch;
   assign bus1.samp_addr  = bus0.samp_addr;
   assign bus1.samp_data  = bus0.samp_data;

   xcorr_peak_finder #(.DATA_W(DATA_W), .TEMPL_LEN(TL), .MAX_LAG(ML), .CH(CH), .MODE_ABS(0))
      u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
   xcorr_peak_finder #(.DATA_W(DATA_W), .TEMPL_LEN(TL), .MAX_LAG(ML), .CH(CH), .MODE_ABS(1))
      u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- vectors and model ----------------
   typedef struct {
      logic [TL*DATA_W-1:0] templ;
      logic [SN*DATA_W-1:0] s0;
      logic [SN*DATA_W-1:0] s1;
      longint v0m0, v1m0, v0m1, v1m1;  // v<ch>m<mode>
      int     l0m0, l1m0, l0m1, l1m1;
   } vec_t;

   vec_t tbl [3];
   int   tm [TL];
   int   sm [CH][SN];
   logic [ACC_W-1:0] exp_q [$];

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic longint get_val(input int d, input int c);
      logic [ACC_W-1:0] r;
      r = (d == 0) ? bus0.peak_val[c*ACC_W +: ACC_W] : bus1.peak_val[c*ACC_W +: ACC_W];
      return longint'($signed(r));
   endfunction

   function automatic longint get_lag(input int d, input int c);
      logic [LAG_W-1:0] r;
      r = (d == 0) ? bus0.peak_lag[c*LAG_W +: LAG_W] : bus1.peak_lag[c*LAG_W +: LAG_W];
      return longint'(r);
   endfunction

   // Correlate every lag, keep the first lag whose metric is the largest.
   task automatic model(input int mode, input int ch, output longint bv, output int bl);
      longint corr, m, bm;
      bv = 0; bl = 0; bm = 0;
      for (int lag = 0; lag <= ML; lag++) begin
         corr = 0;
         for (int j = 0; j < TL; j++) corr += longint'(tm[j]) * longint'(sm[ch][lag + j]);
         m = (mode != 0 && corr < 0) ? -corr : corr;
         if (lag == 0 || m > bm) begin
            bm = m; bv = corr; bl = lag;
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic vec_to_model(input vec_t v);
      for (int k = 0; k < TL; k++) tm[k] = int'($signed(v.templ[k*DATA_W +: DATA_W]));
      for (int k = 0; k < SN; k++) begin
         sm[0][k] = int'($signed(v.s0[k*DATA_W +: DATA_W]));
         sm[1][k] = int'($signed(v.s1[k*DATA_W +: DATA_W]));
      end
   endtask

   task automatic load_model();
      for (int k = 0; k < TL; k++) begin
         bus0.templ_we = 1'b1; bus0.templ_addr = TA_W'(k); bus0.templ_data = 16'(tm[k]);
         tick();
      end
      bus0.templ_we = 1'b0;
      for (int c = 0; c < CH; c++) begin
         for (int k = 0; k < SN; k++) begin
            bus0.samp_we = 1'b1; bus0.samp_ch = 1'(c);
            bus0.samp_addr = SA_W'(k); bus0.samp_data = 16'(sm[c][k]);
            tick();
         end
      end
      bus0.samp_we = 1'b0;
   endtask

   // Launch a run and count clock edges from the start edge to rdy.
   task automatic run(input int ena_off_at, input int ena_off_len, input int restart_at,
                      input int wr_at, input string tag, output int lat);
      logic b1, r1;
      lat = -1; b1 = 1'b0;
      bus0.start = 1'b1;
      tick();
      bus0.start = 1'b0;
      for (int cyc = 1; cyc <= 200; cyc++) begin
         bus0.ena   = (ena_off_len > 0 && cyc > ena_off_at && cyc <= ena_off_at + ena_off_len) ? 1'b0 : 1'b1;
         bus0.start = (cyc == restart_at);
         bus0.samp_we = (cyc == wr_at);
         bus0.samp_ch = 1'b0; bus0.samp_addr = SA_W'(3); bus0.samp_data = 16'd100;
         tick();
         if (cyc == 1) b1 = bus0.busy;
         if (bus0.rdy || bus1.rdy) begin
            lat = cyc;
            check({tag, "_rdy_both"}, longint'({bus0.rdy, bus1.rdy}), 3);
            check({tag, "_busy_at_rdy"}, longint'(bus0.busy), 0);
            break;
         end
      end
      bus0.ena = 1'b1; bus0.start = 1'b0; bus0.samp_we = 1'b0;
      check({tag, "_busy_after_start"}, longint'(b1), 1);
      check({tag, "_latency"}, longint'(lat), longint'(LAT + ena_off_len));
      tick();
      r1 = bus0.rdy;
      check({tag, "_rdy_one_cycle"}, longint'(r1), 0);
   endtask

   task automatic check_peaks(input vec_t v, input string tag);
      check({tag, "_c0_val_m0"}, get_val(0, 0), v.v0m0);
      check({tag, "_c0_lag_m0"}, get_lag(0, 0), longint'(v.l0m0));
      check({tag, "_c1_val_m0"}, get_val(0, 1), v.v1m0);
      check({tag, "_c1_lag_m0"}, get_lag(0, 1), longint'(v.l1m0));
      check({tag, "_c0_val_m1"}, get_val(1, 0), v.v0m1);
      check({tag, "_c0_lag_m1"}, get_lag(1, 0), longint'(v.l0m1));
      check({tag, "_c1_val_m1"}, get_val(1, 1), v.v1m1);
      check({tag, "_c1_lag_m1"}, get_lag(1, 1), longint'(v.l1m1));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int lat;
      logic rdy_seen;
      longint bv;
      int bl;
      logic [ACC_W-1:0] e;

      bus0.ena = 1'b1; bus0.start = 1'b0;
      bus0.templ_we = 1'b0; bus0.templ_addr = '0; bus0.templ_data = '0;
      bus0.samp_we = 1'b0; bus0.samp_ch = '0; bus0.samp_addr = '0; bus0.samp_data = '0;

      // Entry 0: ch0 pulse at 3..6 (positive), ch1 pulse at 5..8 (negative).
      tbl[0].templ = {16'd4, 16'd3, 16'd2, 16'd1};
      tbl[0].s0 = '0; tbl[0].s1 = '0;
      for (int k = 0; k < TL; k++) begin
         tbl[0].s0[(3+k)*DATA_W +: DATA_W] = 16'(k + 1);
         tbl[0].s1[(5+k)*DATA_W +: DATA_W] = 16'(-(k + 1));
      end
      tbl[0].v0m0 = 30; tbl[0].l0m0 = 3; tbl[0].v1m0 = 0;   tbl[0].l1m0 = 0;
      tbl[0].v0m1 = 30; tbl[0].l0m1 = 3; tbl[0].v1m1 = -30; tbl[0].l1m1 = 5;
      // Entry 1: full-scale negative everywhere, all lags tie at 2^32.
      tbl[1].templ = {TL{16'h8000}};
      tbl[1].s0 = {SN{16'h8000}}; tbl[1].s1 = {SN{16'h8000}};
      tbl[1].v0m0 = 64'd4294967296; tbl[1].l0m0 = 0; tbl[1].v1m0 = 64'd4294967296; tbl[1].l1m0 = 0;
      tbl[1].v0m1 = 64'd4294967296; tbl[1].l0m1 = 0; tbl[1].v1m1 = 64'd4294967296; tbl[1].l1m1 = 0;
      // Entry 2: single impulse at the last sample; only lag 7 sees it via tap 3.
      tbl[2].templ = {16'd4, 16'd3, 16'd2, 16'd1};
      tbl[2].s0 = '0; tbl[2].s1 = '0;
      tbl[2].s0[(SN-1)*DATA_W +: DATA_W] = 16'd5;
      tbl[2].s1[(SN-1)*DATA_W +: DATA_W] = -16'sd5;
      tbl[2].v0m0 = 20; tbl[2].l0m0 = 7; tbl[2].v1m0 = 0;   tbl[2].l1m0 = 0;
      tbl[2].v0m1 = 20; tbl[2].l0m1 = 7; tbl[2].v1m1 = -20; tbl[2].l1m1 = 7;

      // Reset state.
      tick(); tick();
      check("rst_busy", longint'(bus0.busy), 0);
      check("rst_rdy", longint'(bus0.rdy | bus1.rdy), 0);
      check("rst_state", longint'(bus0.dbg_state), longint'(ST_IDLE));
      check("rst_peak_val", longint'(bus0.peak_val | bus1.peak_val), 0);
      check("rst_peak_lag", longint'(bus0.peak_lag | bus1.peak_lag), 0);
      rst = 1'b0;
      tick();

      // Table-driven runs.
      for (int i = 0; i < 3; i++) begin
         vec_to_model(tbl[i]);
         load_model();
         run(0, 0, 0, 0, $sformatf("vec%0d", i), lat);
         check_peaks(tbl[i], $sformatf("vec%0d", i));
      end

      // Restart and write attempts during a run are dropped.
      vec_to_model(tbl[0]);
      load_model();
      run(0, 0, 10, 20, "busy_ign", lat);
      check_peaks(tbl[0], "busy_ign");

      // Clock enable low for 5 cycles mid-run.
      run(20, 5, 0, 0, "ena_low", lat);
      check_peaks(tbl[0], "ena_low");

      // Reset mid-run aborts without rdy and keeps stored data.
      bus0.start = 1'b1;
      tick();
      bus0.start = 1'b0;
      repeat (15) tick();
      rst = 1'b1;
      #1;
      check("midrst_busy", longint'(bus0.busy | bus1.busy), 0);
      check("midrst_state", longint'(bus0.dbg_state), longint'(ST_IDLE));
      check("midrst_peak_val", longint'(bus0.peak_val | bus1.peak_val), 0);
      check("midrst_peak_lag", longint'(bus0.peak_lag | bus1.peak_lag), 0);
      tick();
      rst = 1'b0;
      rdy_seen = 1'b0;
      for (int k = 0; k < 60; k++) begin
         tick();
         if (bus0.rdy || bus1.rdy) rdy_seen = 1'b1;
      end
      check("midrst_no_rdy", longint'(rdy_seen), 0);
      run(0, 0, 0, 0, "after_rst", lat);
      check_peaks(tbl[0], "after_rst");

      // Randomized runs against the model.
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < TL; k++)
            tm[k] = (r < 2) ? int'($urandom_range(0, 6)) - 3 : int'($urandom_range(0, 65535)) - 32768;
         for (int c = 0; c < CH; c++)
            for (int k = 0; k < SN; k++)
               sm[c][k] = (r < 2) ? int'($urandom_range(0, 6)) - 3 : int'($urandom_range(0, 65535)) - 32768;
         for (int d = 0; d < 2; d++)
            for (int c = 0; c < CH; c++) begin
               model(d, c, bv, bl);
               exp_q.push_back(ACC_W'(bv));
               exp_q.push_back(ACC_W'(bl));
            end
         load_model();
         run(0, 0, 0, 0, $sformatf("rand%0d", r), lat);
         for (int d = 0; d < 2; d++)
            for (int c = 0; c < CH; c++) begin
               e = exp_q.pop_front();
               check($sformatf("rand%0d_d%0d_c%0d_val", r, d, c), get_val(d, c), longint'($signed(e)));
               e = exp_q.pop_front();
               check($sformatf("rand%0d_d%0d_c%0d_lag", r, d, c), get_lag(d, c), longint'(e));
            end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/xcorr_peak_finder.md
XCORR_PEAK_FINDER -- requirements
Module: xcorr_peak_finder

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_W, 16: signed sample and template width.
- TEMPL_LEN, 32: template length in samples, at least 2.
- MAX_LAG, 64: highest lag searched; lags searched are 0..MAX_LAG.
- CH, 2: number of receive channels.
- MODE_ABS, 0: 1 means the peak search compares |corr|.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: clock.
- rst, in, 1: reset.
- ena, in, 1: global clock enable.
- start, in, 1: run request.
- busy, out, 1: run in progress.
- rdy, out, 1: one-cycle pulse when results are valid.
- templ_we, in, 1: template write strobe.
- templ_addr, in, clog2(TEMPL_LEN): template write address.
- templ_data, in, DATA_W: template write data.
- samp_we, in, 1: sample write strobe.
- samp_ch, in, clog2(CH) (min 1): sample write channel.
- samp_addr, in, clog2(TEMPL_LEN+MAX_LAG): sample write address.
- samp_data, in, DATA_W: sample write data.
- peak_val, out, CH*ACC_W: per-channel signed peak correlation; channel c occupies bits [c*ACC_W +: ACC_W].
- peak_lag, out, CH*clog2(MAX_LAG+1): per-channel lag of the peak, packed the same way.
REQ-003 Reset SHALL be rst, asynchronous, active-high; clock SHALL be clk.

Function
REQ-004 ACC_W SHALL equal 2*DATA_W + clog2(TEMPL_LEN); no accumulation overflow is possible.
REQ-005 For each lag L, corr_c(L) SHALL equal sum over j=0..TEMPL_LEN-1 of templ[j]*samp_c[L+j]; all arithmetic is signed.
REQ-006 The FSM SHALL have the states IDLE, CLEAR, MAC, CMP and DONE; every register advances only on clock edges where ena=1.
REQ-007 IDLE to CLEAR SHALL occur when start=1; in CLEAR, lag=0, j=0, all accumulators are zeroed and busy is set.
REQ-008 CLEAR SHALL go to MAC; MAC performs one multiply-accumulate per channel per cycle, in parallel across channels, for TEMPL_LEN cycles with j running 0..TEMPL_LEN-1.
REQ-009 MAC SHALL go to CMP, where for each channel:
- At lag 0, the peak is unconditionally loaded with the lag-0 result.
- Otherwise, the peak is replaced only if the metric is strictly greater than the stored metric, so the smallest lag wins ties.
- CMP clears the accumulators and j.
REQ-010 CMP SHALL go to MAC with lag+1 if lag<MAX_LAG; otherwise it goes to DONE.
REQ-011 DONE SHALL pulse rdy for one cycle, clear busy and return to IDLE.
REQ-012 Latency SHALL be exact: rdy is high 2+(MAX_LAG+1)*(TEMPL_LEN+1) enabled cycles after the enabled edge that sampled start.
REQ-013 The comparison metric SHALL be corr when MODE_ABS=0 and |corr| when MODE_ABS=1; peak_val always reports the signed corr of the winning lag.
REQ-014 peak_val and peak_lag SHALL change only in CMP and remain stable from rdy until the next run's lag-0 CMP.
REQ-015 start SHALL be ignored while busy=1.
REQ-016 templ_we and samp_we SHALL be honoured only when busy=0; writes while busy=1 are dropped.
REQ-017 The template and sample stores SHALL be register arrays with combinational read.
REQ-018 While ena=0, state, counters, accumulators and outputs SHALL hold, and rdy does not pulse.

Reset
REQ-019 On rst, the following SHALL clear:
- State goes to IDLE.
- busy=0 and rdy=0.
- lag, j, all accumulators, peak_val and peak_lag go to 0.
REQ-020 rst asserted mid-run SHALL abort the run with no rdy pulse; template and sample contents are not reset.

Structure
REQ-021 A package xcorr_pkg SHALL hold the state encoding, the ACC_W computation function and the clog2 helper.
REQ-022 One sub-module, xcorr_mac_lane, instantiated CH times, SHALL hold one channel's accumulator, peak_val/peak_lag registers and metric comparison.

Verification
REQ-023 Parameters SHALL be TEMPL_LEN=4, MAX_LAG=7, CH=2, DATA_W=16; expected latency is 42 cycles.
REQ-024 The bench SHALL cover these scenarios:
- Template {1,2,3,4}; ch0 samples zero except samp[3..6]={1,2,3,4} -> rdy exactly 42 cycles after start; ch0 peak_lag=3, peak_val=30.
- Same template; ch1 samp[5..8]={-1,-2,-3,-4}, other samples 0. With MODE_ABS=0, ch1 peak_lag is 0 and peak_val is 0, because at lag 0 no template tap overlaps a nonzero sample, giving corr=0; every later corr is <=0 and a strict > comparison never replaces the lag-0 result. With MODE_ABS=1, ch1 peak_lag=5 and peak_val=-30.
- All samples and template set to -32768 -> every corr=2^32 and all lags tie; result peak_lag=0, peak_val=4294967296 with no overflow at ACC_W=34.
- start pulsed again at cycle 10 of a run, plus one samp_we at cycle 20 -> both ignored; results and the 42-cycle latency are unchanged.
- ena held low for 5 cycles mid-run -> rdy arrives at cycle 47 with identical results.
- rst asserted at cycle 15 -> busy=0, outputs=0, no rdy pulse; a new start without reloading data reproduces scenario 1.
